wb_sram_ctrl: RTL and testbench

//  Wishbone classic slave driving an external asynchronous 32-bit SRAM (256k x 32 default); initiator side of the SRAM pin interface.

---
 rtl/wb_sram_ctrl_pkg.sv | 44 ++++
 rtl/wb_sram_ctrl.sv | 143 ++++++++++++++
 tb/tb_wb_sram_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_ctrl_pkg.sv
// Shared types and helpers for the Wishbone-to-asynchronous-SRAM controller.
//   state_e    : controller sequencing states
//   wb_req_t   : one sampled Wishbone request (address, data, selects, direction)
//   lane_mask  : expands byte selects into a 32-bit data mask
//   addr_bad   : flags addresses outside the SRAM window or not word aligned
package wb_sram_ctrl_pkg;

  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned SRAM_DW = 32;
  localparam int unsigned SEL_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [WB_DW-1:0] dat;
    logic [WB_AW-1:0] adr;
  } wb_req_t;

  // Byte selects to a data mask; bit 3 covers [31:24].
  function automatic logic [WB_DW-1:0] lane_mask(input logic [SEL_W-1:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int i = 0; i < int'(SEL_W); i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

  // Any set bit above the decoded byte range, or a sub-word offset, is an error.
  function automatic logic addr_bad(input logic [WB_AW-1:0] adr,
                                    input int unsigned      ab_width);
    return ((adr >> (ab_width + 2)) != '0) || (adr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave that turns each bus cycle into one access on an
// external asynchronous 32-bit SRAM, with programmable strobe wait states.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   CYC_I, STB_I, WE_I        Wishbone cycle / strobe / write enable
//   ADR_I, DAT_I, SEL_I       Wishbone byte address, write data, byte selects
//   DAT_O, ACK_O, ERR_O       registered read data, one-clock ack / error pulses
//   sram_addr_o, sram_dat_o   SRAM word address and write data
//   sram_dat_i                SRAM read data
//   sram_ncs_o, sram_noe_o,   active-low chip select, output enable,
//   sram_nwe_o                write enable
//   sram_bsel_o               active-high byte lane enables
module wb_sram_ctrl
  import wb_sram_ctrl_pkg::*;
#(
  parameter int unsigned AB_WIDTH    = 18,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                CYC_I,
  input  logic                STB_I,
  input  logic                WE_I,
  input  logic [WB_AW-1:0]    ADR_I,
  input  logic [WB_DW-1:0]    DAT_I,
  input  logic [SEL_W-1:0]    SEL_I,
  output logic [WB_DW-1:0]    DAT_O,
  output logic                ACK_O,
  output logic                ERR_O,
  output logic [AB_WIDTH-1:0] sram_addr_o,
  output logic [SRAM_DW-1:0]  sram_dat_o,
  input  logic [SRAM_DW-1:0]  sram_dat_i,
  output logic                sram_ncs_o,
  output logic                sram_noe_o,
  output logic                sram_nwe_o,
  output logic [SEL_W-1:0]    sram_bsel_o
);

  localparam int unsigned CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             we_q;

  wb_req_t          req_c;
  logic             request_c;
  logic             bad_c;

  // Snapshot of the bus request as presented this cycle.
  always_comb begin
    req_c     = '{we: WE_I, sel: SEL_I, dat: DAT_I, adr: ADR_I};
    request_c = CYC_I & STB_I;
    bad_c     = addr_bad(req_c.adr, AB_WIDTH);
  end

  // Access sequencer; every pin and bus output is a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      we_q        <= 1'b0;
      DAT_O       <= '0;
      ACK_O       <= 1'b0;
      ERR_O       <= 1'b0;
      sram_addr_o <= '0;
      sram_dat_o  <= '0;
      sram_ncs_o  <= 1'b1;
      sram_noe_o  <= 1'b1;
      sram_nwe_o  <= 1'b1;
      sram_bsel_o <= '0;
    end else begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (request_c) begin
            if (bad_c) begin
              // Rejected without touching the SRAM pins.
              ERR_O <= 1'b1;
              state <= ST_DONE;
            end else begin
              sram_addr_o <= req_c.adr[AB_WIDTH+1:2];
              sram_dat_o  <= req_c.dat;
              sram_bsel_o <= req_c.sel;
              we_q        <= req_c.we;
              sram_ncs_o  <= 1'b0;
              wait_cnt    <= CNT_W'(WAIT_CYCLES);
              if (req_c.we) begin
                state <= ST_SETUP;
              end else begin
                sram_noe_o <= 1'b0;
                state      <= ST_STROBE;
              end
            end
          end
        end

        // Address, data and lanes have settled for a clock before nwe falls.
        ST_SETUP: begin
          sram_nwe_o <= 1'b0;
          wait_cnt   <= CNT_W'(WAIT_CYCLES);
          state      <= ST_STROBE;
        end

        ST_STROBE: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end else begin
            // A master that dropped CYC_I gets no ack, but the pin cycle still ends cleanly.
            ACK_O <= CYC_I;
            if (we_q) begin
              sram_nwe_o <= 1'b1;
              state      <= ST_HOLD;
            end else begin
              DAT_O      <= sram_dat_i & lane_mask(sram_bsel_o);
              sram_ncs_o <= 1'b1;
              sram_noe_o <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end

        // Chip select is kept one clock past nwe so address/data hold after the write edge.
        ST_HOLD: begin
          sram_ncs_o  <= 1'b1;
          sram_bsel_o <= '0;
          state       <= ST_IDLE;
        end

        // Ack/err pulse cycle; the strobe is ignored so it cannot re-issue.
        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Scoreboard bench for wb_sram_ctrl: two instances (no wait states and three
// wait states), each attached to a behavioural asynchronous SRAM. A Wishbone
// driver pushes expected responses; a monitor pops and compares them.
module tb_wb_sram_ctrl;

  localparam int unsigned AB   = 18;
  localparam int          NDUT = 2;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cyc   [NDUT];
  logic          stb   [NDUT];
  logic          we    [NDUT];
  logic [31:0]   adr   [NDUT];
  logic [31:0]   dat_w [NDUT];
  logic [3:0]    sel   [NDUT];
  logic [31:0]   dat_r [NDUT];
  logic          ack   [NDUT];
  logic          err   [NDUT];
  logic [AB-1:0] s_addr[NDUT];
  logic [31:0]   s_wdat[NDUT];
  logic [31:0]   s_rdat[NDUT];
  logic          ncs   [NDUT];
  logic          noe   [NDUT];
  logic          nwe   [NDUT];
  logic [3:0]    bsel  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wb_sram_ctrl #(.AB_WIDTH(AB), .WAIT_CYCLES((g == 0) ? 0 : 3)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .CYC_I      (cyc[g]),
      .STB_I      (stb[g]),
      .WE_I       (we[g]),
      .ADR_I      (adr[g]),
      .DAT_I      (dat_w[g]),
      .SEL_I      (sel[g]),
      .DAT_O      (dat_r[g]),
      .ACK_O      (ack[g]),
      .ERR_O      (err[g]),
      .sram_addr_o(s_addr[g]),
      .sram_dat_o (s_wdat[g]),
      .sram_dat_i (s_rdat[g]),
      .sram_ncs_o (ncs[g]),
      .sram_noe_o (noe[g]),
      .sram_nwe_o (nwe[g]),
      .sram_bsel_o(bsel[g])
    );
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // ---------------- behavioural SRAM (both instances, keyed by dut) ----------
  logic [31:0] sram_mem[int];
  int          cycle;

  function automatic logic [31:0] sram_rd(input int key);
    return sram_mem.exists(key) ? sram_mem[key] : 32'h0;
  endfunction

  initial forever begin
    @(posedge clk);
    cycle++;
    for (int g = 0; g < NDUT; g++) begin
      if (!ncs[g] && !nwe[g]) begin
        sram_mem[g * (1 << AB) + int'(s_addr[g])] =
          merge(sram_rd(g * (1 << AB) + int'(s_addr[g])), s_wdat[g], bsel[g]);
      end
    end
  end

  // Read data appears half a clock after the pins change.
  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      s_rdat[g] = (!ncs[g] && !noe[g]) ? sram_rd(g * (1 << AB) + int'(s_addr[g])) : 32'hBAD0_BAD0;
    end
  end

  // ---------------- pin observers ----------------
  int nwe_run[NDUT], nwe_last[NDUT], noe_run[NDUT], noe_last[NDUT], ncs_low_cnt[NDUT];
  logic [31:0] last_wr_addr[NDUT];

  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      if (!nwe[g]) begin
        nwe_run[g]++;
        last_wr_addr[g] = 32'(s_addr[g]);
      end else if (nwe_run[g] != 0) begin
        nwe_last[g] = nwe_run[g];
        nwe_run[g]  = 0;
      end
      if (!noe[g]) noe_run[g]++;
      else if (noe_run[g] != 0) begin
        noe_last[g] = noe_run[g];
        noe_run[g]  = 0;
      end
      if (!ncs[g]) ncs_low_cnt[g]++;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int          dut;
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
    bit          chk_edge;
    int          at_edge;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t        exp_q[$];
  chk_t        chk_q[$];
  logic [31:0] ref_mem[int];
  int          n_checks;
  int          n_pass;

  function automatic logic [31:0] ref_rd(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Monitor: evaluates posted pin checks and pops one expectation per ACK/ERR.
  initial begin : monitor
    chk_t c;
    exp_t e;
    bit   prev_resp[NDUT];
    bit   now_resp;
    forever begin
      @(negedge clk);
      while (chk_q.size() != 0) begin
        c = chk_q.pop_front();
        do_check(c.name, c.act, c.exp);
      end
      for (int g = 0; g < NDUT; g++) begin
        now_resp = ack[g] | err[g];
        if (now_resp) begin
          do_check("resp_pulse", 32'(prev_resp[g]), 32'd0);
          do_check("resp_queued", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            do_check("resp_dut", 32'(g), 32'(e.dut));
            do_check("resp_err", 32'(err[g]), 32'(e.is_err));
            do_check("resp_ack", 32'(ack[g]), 32'(!e.is_err));
            if (e.chk_data) do_check("rd_data", dat_r[g], e.data);
            if (e.chk_edge) do_check("resp_edge", 32'(cycle + 1), 32'(e.at_edge));
          end
        end
        prev_resp[g] = now_resp;
      end
    end
  end

  // ---------------- Wishbone master ----------------
  // Called at a negedge with the target idle unless the previous call held STB.
  task automatic wb_access(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit hold, input bit chk_lat);
    exp_t e;
    int   key;
    bit   got;
    e.dut      = g;
    e.is_err   = ((a >> (AB + 2)) != 32'h0) || (a[1:0] != 2'b00);
    e.chk_data = 1'b0;
    e.data     = '0;
    e.chk_edge = chk_lat;
    // Request is sampled on the next posedge (cycle + 1).
    if (e.is_err)  e.at_edge = cycle + 2;
    else if (w)    e.at_edge = cycle + 4 + wait_of(g);
    else           e.at_edge = cycle + 3 + wait_of(g);
    if (!e.is_err) begin
      key = g * (1 << AB) + int'(a >> 2);
      if (w) ref_mem[key] = merge(ref_rd(key), d, s);
      else begin
        e.data     = ref_rd(key) & mask_of(s);
        e.chk_data = 1'b1;
      end
    end
    exp_q.push_back(e);
    cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = w; adr[g] = a; dat_w[g] = d; sel[g] = s;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = ack[g] | err[g];
    end
    if (!got) post("ack_timeout", 32'(got), 32'd1);
    if (!hold) begin
      cyc[g] = 1'b0; stb[g] = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic wb_release(input int g);
    cyc[g] = 1'b0; stb[g] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_nwe_low(input int g);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !nwe[g];
    end
    if (!seen) post("nwe_timeout", 32'(seen), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1);
  end

  initial begin : stimulus
    int snap;
    int word;
    int r;
    logic [31:0] a;
    rst = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
      adr[g] = '0; dat_w[g] = '0; sel[g] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      post("rst_ncs",  32'(ncs[g]),    32'd1);
      post("rst_noe",  32'(noe[g]),    32'd1);
      post("rst_nwe",  32'(nwe[g]),    32'd1);
      post("rst_bsel", 32'(bsel[g]),   32'd0);
      post("rst_ack",  32'(ack[g]),    32'd0);
      post("rst_err",  32'(err[g]),    32'd0);
      post("rst_dato", dat_r[g],       32'd0);
      post("rst_addr", 32'(s_addr[g]), 32'd0);
      post("rst_sdat", s_wdat[g],      32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic write/read with no wait states.
    wb_access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
    post("wr_addr",   last_wr_addr[0], 32'd4);
    post("nwe_width", 32'(nwe_last[0]), 32'd1);
    wb_access(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1);
    post("noe_width", 32'(noe_last[0]), 32'd1);
    post("rd_deadbeef", dat_r[0], 32'hDEAD_BEEF);

    // Byte lanes, including an all-lanes-off access.
    wb_access(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 1'b1);
    wb_access(0, 1'b1, 32'h0000_0020, 32'hAA00_0000, 4'h8, 1'b0, 1'b1);
    wb_access(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b1);
    post("lane_merge", dat_r[0], 32'hAA22_3344);
    wb_access(0, 1'b0, 32'h0000_0020, 32'h0, 4'h3, 1'b0, 1'b1);
    post("lane_low", dat_r[0], 32'h0000_3344);
    wb_access(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1);
    wb_access(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, 1'b1);
    post("sel0_read", dat_r[0], 32'h0);
    wb_access(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b1);

    // Top of the window and just past it.
    wb_access(0, 1'b1, 32'h000F_FFFC, 32'h5A5A_A5A5, 4'hF, 1'b0, 1'b1);
    post("top_addr", last_wr_addr[0], 32'h0003_FFFF);
    wb_access(0, 1'b0, 32'h000F_FFFC, 32'h0, 4'hF, 1'b0, 1'b1);

    // Error responses never touch the SRAM.
    snap = ncs_low_cnt[0];
    wb_access(0, 1'b0, 32'h0100_0000, 32'h0, 4'hF, 1'b0, 1'b1);
    wb_access(0, 1'b0, 32'h0000_0002, 32'h0, 4'hF, 1'b0, 1'b1);
    wb_access(0, 1'b1, 32'h0010_0000, 32'h1, 4'hF, 1'b0, 1'b1);
    post("err_no_ncs", 32'(ncs_low_cnt[0]), 32'(snap));

    // Three wait states.
    wb_access(1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
    post("nwe_width_w3", 32'(nwe_last[1]), 32'd4);
    wb_access(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b1);
    post("noe_width_w3", 32'(noe_last[1]), 32'd4);

    // Back-to-back with STB held: one response per access.
    wb_access(1, 1'b1, 32'h0000_0024, 32'h0102_0304, 4'hF, 1'b1, 1'b1);
    wb_access(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1, 1'b0);
    wb_access(1, 1'b0, 32'h0000_0024, 32'h0, 4'hF, 1'b1, 1'b0);
    wb_access(1, 1'b0, 32'h0000_0024, 32'h0, 4'h6, 1'b1, 1'b0);
    wb_release(1);
    repeat (10) @(negedge clk);

    // CYC dropped mid-strobe: full write pulse, no ack.
    ref_mem[1 * (1 << AB) + 16] = 32'h7777_8888;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h0000_0040;
    dat_w[1] = 32'h7777_8888; sel[1] = 4'hF;
    wait_nwe_low(1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (12) @(negedge clk);
    post("abort_nwe_width", 32'(nwe_last[1]), 32'd4);
    wb_access(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b1);

    // Reset during a write strobe releases the pins on the next clock.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h0000_0080;
    dat_w[1] = 32'h1234_5678; sel[1] = 4'hF;
    wait_nwe_low(1);
    rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    post("rstmid_nwe",  32'(nwe[1]),  32'd1);
    post("rstmid_ncs",  32'(ncs[1]),  32'd1);
    post("rstmid_noe",  32'(noe[1]),  32'd1);
    post("rstmid_bsel", 32'(bsel[1]), 32'd0);
    post("rstmid_dato", dat_r[1],     32'd0);
    rst = 1'b0;
    @(negedge clk);
    wb_access(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b1);

    // Randomized traffic against the reference memory (words 0..31 only).
    for (int g = 0; g < NDUT; g++) begin
      for (int n = 0; n < 40; n++) begin
        word = int'($urandom_range(0, 31));
        r    = int'($urandom_range(0, 9));
        a    = 32'(word) << 2;
        if (r == 0)      a = 32'h0100_0000 | a;
        else if (r == 1) a = a | 32'($urandom_range(1, 3));
        wb_access(g, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
      end
    end

    repeat (10) @(negedge clk);
    post("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
